// File: rtl/layer_compositor.sv
// Purpose : pick the highest-priority opaque layer per pixel, apply a frame-synchronous
//           global fade and drive the 12-bit VGA pins with matching hsync/vsync delay.
// Latency : 2 cycles from layer_color/hs_in/vs_in/rdn_in to r/g/b/hs/vs; no backpressure (pixel stream).
// Ports   : clk/rst (sync, active-high); layer_color/layer_disp per-layer colour and display flag;
//           hs_in/vs_in/rdn_in raster timing; fade_in_req/fade_out_req one-cycle fade requests;
//           r/g/b/hs/vs VGA outputs; fade_level current brightness 0..16; fade_done endpoint pulse.
module layer_compositor #(
  parameter int          N_LAYERS    = 4,
  parameter logic [15:0] KEY_COLOR   = 16'hffff,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter int          FADE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16*N_LAYERS-1:0] layer_color,
  input  logic [N_LAYERS-1:0]   layer_disp,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  rdn_in,
  input  logic                  fade_in_req,
  input  logic                  fade_out_req,
  output logic [3:0]            r,
  output logic [3:0]            g,
  output logic [3:0]            b,
  output logic                  hs,
  output logic                  vs,
  output logic [4:0]            fade_level,
  output logic                  fade_done
);

  // Frame counter width; a 1-frame step still needs a 1-bit counter.
  localparam int CW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES - 1);

  // Only the 4 MSBs of each RGB565 channel reach the pins, so stage 1 keeps just those.
  localparam logic [11:0] BG_C4 = {BG_COLOR[15:12], BG_COLOR[10:7], BG_COLOR[4:1]};

  typedef enum logic [1:0] {
    ST_BLACK,
    ST_FADE_IN,
    ST_SHOW,
    ST_FADE_OUT
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: layer selection
  // ---------------------------------------------------------------------------
  logic [11:0] sel_c4_d;
  logic [11:0] c4_q;
  logic        hs1_q;
  logic        vs1_q;
  logic        rdn1_q;

  // Walk from the lowest priority upward so the lowest opaque index wins.
  always_comb begin
    sel_c4_d = BG_C4;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_disp[i] && (layer_color[16*i +: 16] != KEY_COLOR)) begin
        sel_c4_d = {layer_color[16*i+12 +: 4], layer_color[16*i+7 +: 4], layer_color[16*i+1 +: 4]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c4_q   <= BG_C4;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      rdn1_q <= 1'b1;
    end else begin
      c4_q   <= sel_c4_d;
      hs1_q  <= hs_in;
      vs1_q  <= vs_in;
      rdn1_q <= rdn_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Fade control
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    fade_level_q;
  logic          fade_done_q;
  logic          vs_prev_q;
  logic          tick;
  logic          fading;

  assign tick   = vs_prev_q & ~vs_in;
  assign fading = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);

  // Requests take precedence over a step landing in the same cycle; fade_out is
  // checked first so it wins when both requests are valid together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SHOW;
      cnt_q        <= '0;
      fade_level_q <= 5'd16;
      fade_done_q  <= 1'b0;
      vs_prev_q    <= 1'b1;
    end else begin
      vs_prev_q   <= vs_in;
      fade_done_q <= 1'b0;
      if (fade_out_req && (state_q == ST_SHOW || state_q == ST_FADE_IN)) begin
        state_q <= ST_FADE_OUT;
        cnt_q   <= '0;
      end else if (fade_in_req && (state_q == ST_BLACK || state_q == ST_FADE_OUT)) begin
        state_q <= ST_FADE_IN;
        cnt_q   <= '0;
      end else if (tick && fading) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          if (state_q == ST_FADE_IN) begin
            fade_level_q <= fade_level_q + 5'd1;
            if (fade_level_q == 5'd15) begin
              state_q     <= ST_SHOW;
              fade_done_q <= 1'b1;
            end
          end else begin
            fade_level_q <= fade_level_q - 5'd1;
            if (fade_level_q == 5'd1) begin
              state_q     <= ST_BLACK;
              fade_done_q <= 1'b1;
            end
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: blanking and brightness scaling
  // ---------------------------------------------------------------------------
  logic [3:0] r_d;
  logic [3:0] g_d;
  logic [3:0] b_d;
  logic [3:0] r_q;
  logic [3:0] g_q;
  logic [3:0] b_q;
  logic       hs_q;
  logic       vs_q;

  // 15*16 = 240 fits in 9 bits; >>4 then truncate keeps level 16 as unity gain.
  always_comb begin
    r_d = 4'(({5'd0, c4_q[11:8]} * {4'd0, fade_level_q}) >> 4);
    g_d = 4'(({5'd0, c4_q[7:4]}  * {4'd0, fade_level_q}) >> 4);
    b_d = 4'(({5'd0, c4_q[3:0]}  * {4'd0, fade_level_q}) >> 4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= 4'd0;
      g_q  <= 4'd0;
      b_q  <= 4'd0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= hs1_q;
      vs_q <= vs1_q;
      if (rdn1_q) begin
        r_q <= 4'd0;
        g_q <= 4'd0;
        b_q <= 4'd0;
      end else begin
        r_q <= r_d;
        g_q <= g_d;
        b_q <= b_d;
      end
    end
  end

  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign hs         = hs_q;
  assign vs         = vs_q;
  assign fade_level = fade_level_q;
  assign fade_done  = fade_done_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Testbench for layer_compositor: directed vectors feed a scoreboard of expected
// pixel and fade results, checked by an independent negedge monitor.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] layer_color;
  logic [3:0]  layer_disp;
  logic        hs_in, vs_in, rdn_in, fade_in_req, fade_out_req;
  logic [3:0]  r, g, b;
  logic        hs, vs;
  logic [4:0]  fade_level;
  logic        fade_done;

  layer_compositor dut (
    .clk          (clk),
    .rst          (rst),
    .layer_color  (layer_color),
    .layer_disp   (layer_disp),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .rdn_in       (rdn_in),
    .fade_in_req  (fade_in_req),
    .fade_out_req (fade_out_req),
    .r            (r),
    .g            (g),
    .b            (b),
    .hs           (hs),
    .vs           (vs),
    .fade_level   (fade_level),
    .fade_done    (fade_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [13:0] val;
  } exp_t;

  exp_t pix_q[$];
  exp_t fade_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic end_req = 1'b0;

  function automatic logic [13:0] px(input logic [3:0] er, eg, eb, input logic eh, ev);
    return {er, eg, eb, eh, ev};
  endfunction

  // Inputs driven just after a rising edge are sampled by the next edge; the pixel
  // result lands two edges later and the fade state one edge later.
  task automatic drive(input logic [63:0] col, input logic [3:0] disp,
                       input logic h, v, rd, fi, fo, rs, input logic [13:0] exp_pix);
    @(posedge clk);
    #1;
    layer_color  = col;
    layer_disp   = disp;
    hs_in        = h;
    vs_in        = v;
    rdn_in       = rd;
    fade_in_req  = fi;
    fade_out_req = fo;
    rst          = rs;
    pix_q.push_back('{due: cyc + 2, val: exp_pix});
  endtask

  task automatic exp_fade(input logic [4:0] lvl, input logic dn);
    fade_q.push_back('{due: cyc + 1, val: {8'd0, lvl, dn}});
  endtask

  // One frame: vs high then vs low (the falling edge is the tick). fi is raised on the tick cycle.
  task automatic frame(input logic fi, input logic [4:0] pre, post, input logic dn,
                       input logic [15:0] c0, input logic rd, input logic [3:0] ec);
    drive({48'd0, c0}, 4'b0001, 1'b1, 1'b1, rd, 1'b0, 1'b0, 1'b0, px(ec, ec, ec, 1'b1, 1'b1));
    exp_fade(pre, 1'b0);
    drive({48'd0, c0}, 4'b0001, 1'b1, 1'b0, rd, fi, 1'b0, 1'b0, px(ec, ec, ec, 1'b1, 1'b0));
    exp_fade(post, dn);
  endtask

  // Monitor: compares whatever expectation falls due on this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      e = pix_q.pop_front();
      n_vec++;
      if (e.due != cyc) begin
        n_bad++;
        $display("FAIL pix_missed due=%0d now=%0d", e.due, cyc);
      end else if ({r, g, b, hs, vs} !== e.val) begin
        n_bad++;
        $display("FAIL pixel cyc=%0d got r=%h g=%h b=%h hs=%b vs=%b want r=%h g=%h b=%h hs=%b vs=%b",
                 cyc, r, g, b, hs, vs, e.val[13:10], e.val[9:6], e.val[5:2], e.val[1], e.val[0]);
      end
    end
    while (fade_q.size() > 0 && fade_q[0].due <= cyc) begin
      e = fade_q.pop_front();
      n_vec++;
      if (e.due != cyc) begin
        n_bad++;
        $display("FAIL fade_missed due=%0d now=%0d", e.due, cyc);
      end else if ({fade_level, fade_done} !== e.val[5:0]) begin
        n_bad++;
        $display("FAIL fade cyc=%0d got level=%0d done=%b want level=%0d done=%b",
                 cyc, fade_level, fade_done, e.val[5:1], e.val[0]);
      end
    end
    if (end_req) begin
      n_vec++;
      if (pix_q.size() != 0 || fade_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain pending pix=%0d fade=%0d want 0", pix_q.size(), fade_q.size());
      end
    end
  end

  localparam logic [63:0] RED   = {48'd0, 16'hF800};
  localparam logic [63:0] MIX_A = {16'h0000, 16'h0000, 16'h07E0, 16'hFFFF};
  localparam logic [63:0] MIX_B = {16'h0000, 16'h0000, 16'h07E0, 16'h001F};
  localparam logic [63:0] MIX_C = {16'h0000, 16'h8410, 16'h07E0, 16'hFFFF};
  localparam logic [63:0] WHITE = {48'd0, 16'hFFFE};

  initial begin
    rst = 1'b1; layer_color = '0; layer_disp = '0;
    hs_in = 1'b1; vs_in = 1'b1; rdn_in = 1'b1; fade_in_req = 1'b0; fade_out_req = 1'b0;

    // Reset state
    repeat (3) drive('0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, px(0, 0, 0, 1, 1));
    exp_fade(5'd16, 1'b0);

    // Selection, priority, key colour, background and timing passthrough
    drive(RED,   4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(4'hF, 0, 0, 0, 1));
    drive(RED,   4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, px(4'hF, 0, 0, 1, 0));
    drive(RED,   4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, px(4'hF, 0, 0, 0, 0));
    drive(RED,   4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(4'hF, 0, 0, 1, 1));
    drive(MIX_A, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(0, 4'hF, 0, 1, 1));
    drive(MIX_B, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(0, 4'hF, 0, 1, 1));
    drive(MIX_B, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(0, 0, 4'hF, 1, 1));
    drive(MIX_C, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(4'h8, 4'h8, 4'h8, 1, 1));
    drive(MIX_C, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(0, 0, 0, 1, 1));
    // Blanking with opaque layers present
    drive(RED,   4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, px(0, 0, 0, 0, 0));
    drive(RED,   4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, px(0, 0, 0, 1, 1));

    // Full fade out: 32 ticks, one step every 2 ticks; white at level 8 gives 7
    drive('0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, px(0, 0, 0, 1, 1));
    exp_fade(5'd16, 1'b0);
    for (int t = 1; t <= 32; t++) begin
      frame(1'b0, 5'(16 - (t - 1) / 2), 5'(16 - t / 2), t == 32,
            (t == 17) ? 16'hFFFE : 16'h0000, (t == 17) ? 1'b0 : 1'b1, (t == 17) ? 4'h7 : 4'h0);
    end
    drive(WHITE, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(0, 0, 0, 1, 1));
    exp_fade(5'd0, 1'b0);

    // Fade in from black to level 10
    drive('0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, px(0, 0, 0, 1, 1));
    exp_fade(5'd0, 1'b0);
    for (int t = 1; t <= 20; t++) frame(1'b0, 5'((t - 1) / 2), 5'(t / 2), 1'b0, 16'h0, 1'b1, 4'h0);

    // Both requests in FADE_IN: fade out wins; white at level 10 gives 9
    drive(WHITE, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, px(4'h9, 4'h9, 4'h9, 1, 1));
    exp_fade(5'd10, 1'b0);
    frame(1'b0, 5'd10, 5'd10, 1'b0, 16'h0, 1'b1, 4'h0);
    // fade_in_req lands on a step tick: request wins, level stays 10
    frame(1'b1, 5'd10, 5'd10, 1'b0, 16'h0, 1'b1, 4'h0);
    for (int t = 1; t <= 12; t++) frame(1'b0, 5'(10 + (t - 1) / 2), 5'(10 + t / 2), t == 12, 16'h0, 1'b1, 4'h0);

    // fade_in_req in SHOW is ignored: level holds across a would-be step
    drive('0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, px(0, 0, 0, 1, 1));
    exp_fade(5'd16, 1'b0);
    repeat (2) frame(1'b0, 5'd16, 5'd16, 1'b0, 16'h0, 1'b1, 4'h0);

    // Reset mid-fade
    drive('0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, px(0, 0, 0, 1, 1));
    exp_fade(5'd16, 1'b0);
    for (int t = 1; t <= 4; t++) frame(1'b0, 5'(16 - (t - 1) / 2), 5'(16 - t / 2), 1'b0, 16'h0, 1'b1, 4'h0);
    // This pixel's output slot coincides with the reset edge, so it reads as reset values.
    drive(RED, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(0, 0, 0, 1, 1));
    exp_fade(5'd14, 1'b0);
    drive(RED, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, px(0, 0, 0, 1, 1));
    exp_fade(5'd16, 1'b0);
    drive(RED, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, px(4'hF, 0, 0, 0, 1));
    exp_fade(5'd16, 1'b0);
    repeat (2) drive('0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, px(0, 0, 0, 1, 1));

    repeat (4) @(posedge clk);
    end_req = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
